booth_mul_r4: RTL
=================

# booth_mul_r4

Parametrised, iterative, radix-4 Booth multiplier: the next generation of the 8-bit switch-loaded Booth unit. Operands arrive in parallel with a start/done handshake, and the operand width is a parameter. One Booth digit is retired per clock. The block sits behind the board-level display/controller glue and also serves as a reusable multiply engine for wider datapaths.

## Interface
- `W`, default 8: operand width; must be even and ≥ 4.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when the block is in IDLE or DONE.
- `a` input W: multiplicand; captured on the accepting edge.
- `b` input W: multiplier; captured on the accepting edge.
- `op_signed` input 1: 1 = two's-complement operands, 0 = unsigned. Present only with `BOOTH_UNSIGNED_EN`.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse when `product` becomes valid.
- `product` output 2W: result; held until the next accepted start.
- `state` output 3: debug encoding of the FSM (IDLE=0, RUN=1, DONE=2).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE→RUN when `start`=1; `a`, `b` (and `op_signed`) are captured on that edge.
- RUN lasts exactly W/2+1 cycles, counted by a down-counter of width clog2(W/2+2). RUN→DONE when the counter expires.
- DONE→RUN if `start`=1 (back-to-back operation); otherwise DONE→IDLE.
- `start` is ignored while in RUN: no re-capture, no restart.
- Operand extension:
  - Both operands are extended to W+2 bits. Extension is sign extension for signed operation and zero extension for unsigned.
  - This gives a uniform W/2+1 digits in both modes. In signed mode the extra top digit is always 0.
- Digit i uses triple {b[2i+1], b[2i], b[2i−1]}, with b[−1]=0:
  - 000, 111 → 0
  - 001, 010 → +A
  - 011 → +2A
  - 100 → −2A
  - 101, 110 → −A
- Accumulator:
  - Width 2W+4, signed.
  - Each RUN cycle adds the selected multiple (±A or ±2A, width W+3) into the upper part of the accumulator, then shifts the accumulator arithmetic-right by 2.
  - Negation is one's-complement plus carry-in. No separate negator stage.
- `product` = low 2W bits of the final accumulator. The result is exact for all inputs, including −2^(W−1) × −2^(W−1).
- Reset values: `state`=IDLE, `busy`=0, `done`=0, `product`=0. The accumulator and counter are cleared.
- Reset mid-RUN aborts the operation. The next cycle is IDLE with the reset values above, and no `done` pulse is produced.
- Reset takes priority over `start` in the same cycle.

## Timing
- `start` accepted at edge k:
  - `busy`=1 from cycle k+1 through k+W/2+1.
  - `done`=1 and `product` valid in cycle k+W/2+2.
- Latency is W/2+2 cycles (6 cycles for W=8).
- `done` is high for exactly one cycle per completed operation.
- `product` changes only on the edge that enters DONE, or on reset. It is stable during IDLE and RUN.
- Throughput with back-to-back starts: one result every W/2+2 cycles, because `start` is accepted in the DONE cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `BOOTH_UNSIGNED_EN`.
- Defined:
  - The `op_signed` port exists.
  - The extension mode is latched per operation at the accepting edge.
- Undefined:
  - The `op_signed` port is absent.
  - Operation is always two's-complement (equivalent to `op_signed`=1).
  - Extension logic reduces to sign extension only.

## Structure
- Package `booth_pkg`:
  - State enum (IDLE=3'd0, RUN=3'd1, DONE=3'd2).
  - Booth digit enum (ZERO, POS1, POS2, NEG1, NEG2).
  - Triple-decode function.
- Sub-module `booth_r4_digit`:
  - Combinational: triple plus extended A in; selected multiple (W+3 bits) and negate flag out.
  - Parametrised by `W`.
- Top-level `booth_mul_r4` holds the FSM, counter, operand and accumulator registers, and the output registers.

## Test plan
- W=8, signed: a=0x80, b=0x80 (−128×−128) → `product`=0x4000, `done` six cycles after the start edge.
- W=8, signed: a=0x7F, b=0xFF (127×−1) → `product`=0xFF81. Also a=0, b=0x55 → 0x0000.
- `BOOTH_UNSIGNED_EN`, W=8: a=0xFF, b=0xFF with `op_signed`=0 → 0xFE01; same operands with `op_signed`=1 → 0x0001.
- `start` pulsed again in the third RUN cycle with different operands → ignored; the original result is delivered on time, with a single `done` pulse.
- `rst` asserted in the second RUN cycle → next cycle `state`=0, `busy`=0, `product`=0; no `done` pulse follows.
- W=16 random regression, 10k signed operations plus back-to-back starts issued in DONE → every result matches the reference a×b, and each `done` follows its start by exactly 10 cycles.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digit
// codes and the triple decoder.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    DONE = 3'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_e;

  // Map a multiplier triple {b[2i+1], b[2i], b[2i-1]} to its Booth digit
  function automatic digit_e booth_decode(input logic [2:0] triple);
    digit_e dig;
    dig = ZERO;
    case (triple)
      3'b001, 3'b010: dig = POS1;
      3'b011:         dig = POS2;
      3'b100:         dig = NEG2;
      3'b101, 3'b110: dig = NEG1;
      default:        dig = ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Radix-4 Booth digit selector: picks 0, +-A or +-2A for one multiplier
// triple. Negative multiples leave as one's complement; the caller adds
// neg_c as the carry-in to complete the two's-complement negation.
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [2:0]   triple,
  input  logic [W+1:0] a_ext,
  output logic [W+2:0] mult_c,
  output logic         neg_c
);

  digit_e       dig_c;
  logic [W+2:0] mag_c;

  // Decode the triple, select the magnitude and conditionally invert it
  always_comb begin
    dig_c  = booth_decode(triple);
    mag_c  = '0;
    neg_c  = 1'b0;
    mult_c = '0;
    case (dig_c)
      POS1: mag_c = {a_ext[W+1], a_ext};
      POS2: mag_c = {a_ext, 1'b0};
      NEG1: begin
        mag_c = {a_ext[W+1], a_ext};
        neg_c = 1'b1;
      end
      NEG2: begin
        mag_c = {a_ext, 1'b0};
        neg_c = 1'b1;
      end
      default: mag_c = '0;
    endcase
    mult_c = neg_c ? ~mag_c : mag_c;
  end

endmodule

// File: rtl/booth_mul_r4.sv
// Iterative radix-4 Booth multiplier with start/done handshake, one digit
// retired per clock. Optional feature macro: BOOTH_UNSIGNED_EN adds the
// op_signed port selecting unsigned (zero-extended) operation per request.
module booth_mul_r4
  import booth_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
`ifdef BOOTH_UNSIGNED_EN
  input  logic           op_signed,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic [2:0]     state
);

  localparam int unsigned NDIG = W / 2 + 1;          // digits per operation
  localparam int unsigned CW   = $clog2(W / 2 + 2);  // RUN down-counter width
  localparam int unsigned XW   = W + 2;              // extended operand width
  localparam int unsigned AW   = 2 * W + 4;          // accumulator width
  localparam int unsigned SW   = AW + 1;             // pre-shift sum width

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [XW-1:0]  a_q, a_d;
  logic [XW:0]    b_q, b_d;        // extended multiplier with b[-1] in bit 0
  logic [AW-1:0]  acc_q, acc_d;
  logic [2*W-1:0] product_q, product_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           sgn_c;
  logic [XW-1:0]  a_ext_c;
  logic [XW-1:0]  b_ext_c;
  logic [W+2:0]   dig_mult_c;
  logic           dig_neg_c;
  logic [SW-1:0]  sum_c;

`ifdef BOOTH_UNSIGNED_EN
  assign sgn_c = op_signed;
`else
  assign sgn_c = 1'b1;
`endif

  // Extend both operands to W+2 bits so every mode sees W/2+1 digits
  assign a_ext_c = {{2{sgn_c & a[W-1]}}, a};
  assign b_ext_c = {{2{sgn_c & b[W-1]}}, b};

  booth_r4_digit #(.W(W)) u_digit (
    .triple (b_q[2:0]),
    .a_ext  (a_q),
    .mult_c (dig_mult_c),
    .neg_c  (dig_neg_c)
  );

  // Add the selected multiple plus carry-in at the top of the accumulator
  always_comb begin
    sum_c = SW'({acc_q[AW-1], acc_q})
          + {dig_mult_c, {(W + 2){1'b0}}}
          + SW'({dig_neg_c, {(W + 2){1'b0}}});
  end

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CW'(NDIG - 1);
          a_d     = a_ext_c;
          b_d     = {b_ext_c, 1'b0};
          acc_d   = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = AW'($signed(sum_c) >>> 2);
        b_d   = {2'b00, b_q[XW:2]};
        if (cnt_q == '0) begin
          state_d   = DONE;
          product_d = acc_d[2*W-1:0];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign state   = state_q;

endmodule
